// File: rtl/bp_be_loop_trip_estimator_pkg.sv
// Shared types for the loop trip-count estimator: channel states, normalised branch ops,
// divider request format and the branch-operand normalisation helper.
package bp_be_pkg;

    localparam int vaddr_width_gp      = 39;
    localparam int dpath_width_gp      = 64;
    localparam int rv64_instr_width_gp = 32;
    localparam int lte_id_width_gp     = 8;
    localparam logic [6:0] rv64_branch_opcode_gp = 7'b1100011;

    typedef enum logic [2:0] {
        e_idle, e_scout, e_wait2, e_divq, e_div, e_waitconf, e_done
    } lte_state_e;

    typedef enum logic [2:0] {
        e_op_lt, e_op_ltu, e_op_ge, e_op_geu, e_op_ne, e_op_none
    } lte_op_e;

    typedef struct packed {
        logic [lte_id_width_gp-1:0] id;
        logic [dpath_width_gp-1:0]  d;
        logic [dpath_width_gp-1:0]  s;
    } lte_div_req_s;

    typedef struct packed {
        logic [dpath_width_gp-1:0] d;
        logic [dpath_width_gp-1:0] s;
    } lte_norm_s;

    function automatic lte_op_e decode_op(input logic [2:0] funct3);
        case (funct3)
            3'b001:  decode_op = e_op_ne;
            3'b100:  decode_op = e_op_lt;
            3'b101:  decode_op = e_op_ge;
            3'b110:  decode_op = e_op_ltu;
            3'b111:  decode_op = e_op_geu;
            default: decode_op = e_op_none;
        endcase
    endfunction

    // d = distance still to cover (from sample 2), s = progress per iteration (sample2 - sample1)
    function automatic lte_norm_s normalise(input lte_op_e op,
                                            input logic [dpath_width_gp-1:0] rs1_a,
                                            input logic [dpath_width_gp-1:0] rs2_a,
                                            input logic [dpath_width_gp-1:0] rs1_b,
                                            input logic [dpath_width_gp-1:0] rs2_b);
        logic [dpath_width_gp-1:0] d1, d2, d, s;
        d1 = rs1_b - rs1_a;
        d2 = rs2_b - rs2_a;
        d  = rs2_b - rs1_b;
        s  = d1 - d2;
        case (op)
            e_op_ge, e_op_geu: begin
                d = rs1_b - rs2_b + dpath_width_gp'(1);
                s = d2 - d1;
            end
            e_op_ne: begin
                if (d[dpath_width_gp-1] != s[dpath_width_gp-1]) begin
                    d = '0 - d;
                    s = '0 - s;
                end
            end
            default: ;
        endcase
        normalise.d = d;
        normalise.s = s;
    endfunction

endpackage

// File: rtl/bp_be_loop_trip_estimator_if.sv
// Result port of the trip estimator: channel-tagged count with valid/yumi handshake.
interface bp_be_loop_trip_estimator_if #(
    parameter int id_width_p    = 2,
    parameter int count_width_p = 8
);
    logic                     v_o;
    logic [id_width_p-1:0]    id_o;
    logic [count_width_p-1:0] trip_count_o;
    logic                     exact_o;
    logic                     yumi_i;

    modport master (output v_o, id_o, trip_count_o, exact_o, input yumi_i);
    modport slave  (input v_o, id_o, trip_count_o, exact_o, output yumi_i);
endinterface

// File: rtl/bp_be_loop_trip_div.sv
// Serial restoring unsigned divider, one quotient bit per cycle; the request id rides along
// so the owner can tell which channel the result belongs to.
module bp_be_loop_trip_div
    import bp_be_pkg::*;
(
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       req_v_i,
    output logic                       req_ready_o,
    input  lte_div_req_s               req_i,
    output logic                       res_v_o,
    output logic [lte_id_width_gp-1:0] res_id_o,
    output logic [dpath_width_gp-1:0]  res_quo_o
);
    localparam int W       = dpath_width_gp;
    localparam int cnt_w_lp = $clog2(W + 1);

    logic                       r_busy, r_res_v;
    logic [cnt_w_lp-1:0]        r_cnt;
    logic [W-1:0]               r_quo, r_den, r_rem;
    logic [lte_id_width_gp-1:0] r_id;
    logic [W:0]                 w_rem_shift, w_rem_sub;
    logic                       w_ge;

    assign w_rem_shift = {r_rem, r_quo[W-1]};
    assign w_rem_sub   = w_rem_shift - {1'b0, r_den};
    // no borrow out of the W+1 bit subtract means the shifted remainder covers the divisor
    assign w_ge        = !w_rem_sub[W];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_busy  <= 1'b0;
            r_res_v <= 1'b0;
            r_cnt   <= '0;
            r_quo   <= '0;
            r_den   <= '0;
            r_rem   <= '0;
            r_id    <= '0;
        end else begin
            r_res_v <= 1'b0;
            if (req_v_i && !r_busy) begin
                r_busy <= 1'b1;
                r_cnt  <= cnt_w_lp'(W);
                r_quo  <= req_i.d;
                r_den  <= req_i.s;
                r_rem  <= '0;
                r_id   <= req_i.id;
            end else if (r_busy) begin
                r_rem <= w_ge ? w_rem_sub[W-1:0] : w_rem_shift[W-1:0];
                r_quo <= {r_quo[W-2:0], w_ge};
                r_cnt <= r_cnt - cnt_w_lp'(1);
                if (r_cnt == cnt_w_lp'(1)) begin
                    r_busy  <= 1'b0;
                    r_res_v <= 1'b1;
                end
            end
        end
    end

    assign req_ready_o = !r_busy;
    assign res_v_o     = r_res_v;
    assign res_id_o    = r_id;
    assign res_quo_o   = r_quo;
endmodule

// File: rtl/bp_be_loop_trip_estimator.sv
// Multi-channel loop trip-count estimator: each channel finds the backward branch closing a
// striding-load loop, samples it twice, and turns the operand deltas into remaining iterations.
module bp_be_loop_trip_estimator
    import bp_be_pkg::*;
#(
    parameter int channels_p      = 4,
    parameter int count_width_p   = 8,
    parameter int default_count_p = 128,
    parameter int timeout_p       = 1024,
    parameter int vaddr_width_p   = vaddr_width_gp,
    localparam int id_width_lp    = (channels_p > 1) ? $clog2(channels_p) : 1
)(
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           br_v_i,
    input  logic [rv64_instr_width_gp-1:0] br_instr_i,
    input  logic [vaddr_width_p-1:0]       br_pc_i,
    input  logic [dpath_width_gp-1:0]      br_rs1_i,
    input  logic [dpath_width_gp-1:0]      br_rs2_i,
    input  logic                           start_v_i,
    input  logic [id_width_lp-1:0]         start_id_i,
    input  logic [vaddr_width_p-1:0]       striding_pc_i,
    input  logic                           confirm_v_i,
    input  logic [id_width_lp-1:0]         confirm_id_i,
    bp_be_loop_trip_estimator_if.master    res_if
);
    localparam int W        = dpath_width_gp;
    localparam int timer_lp = $clog2(timeout_p + 1);

    lte_state_e                r_state [channels_p];
    lte_state_e                w_state_next [channels_p];
    lte_op_e                   r_op [channels_p];
    logic [channels_p-1:0]     r_conf, w_conf_next, r_triv, r_exact_ch;
    logic [vaddr_width_p-1:0]  r_spc [channels_p];
    logic [vaddr_width_p-1:0]  r_pc [channels_p];
    logic [W-1:0]              r_rs1 [channels_p];
    logic [W-1:0]              r_rs2 [channels_p];
    logic [W-1:0]              r_num [channels_p];
    logic [W-1:0]              r_den [channels_p];
    logic [count_width_p-1:0]  r_cnt_ch [channels_p];
    logic [timer_lp-1:0]       r_timer [channels_p];
    lte_norm_s                 w_norm [channels_p];

    logic [channels_p-1:0] w_start_hit, w_conf_hit, w_scout_acc, w_wait2_hit, w_timeout;
    logic [channels_p-1:0] w_div_req, w_div_done, w_done, w_yumi_hit, w_out_mask;

    logic [vaddr_width_p-1:0]   w_imm, w_target;
    logic                       w_backward, w_unused_instr;
    lte_op_e                    w_br_op;
    logic                       w_grant_v, w_div_ready, w_div_go, w_res_v, w_sat;
    logic [id_width_lp-1:0]     w_grant_id, r_rr, w_sel_id;
    logic                       w_sel_v;
    lte_div_req_s               w_div_req_s;
    logic [lte_id_width_gp-1:0] w_res_id;
    logic [W-1:0]               w_res_quo;

    logic                     r_v, r_out_exact;
    logic [id_width_lp-1:0]   r_out_id;
    logic [count_width_p-1:0] r_out_cnt;

    assign w_imm = {{(vaddr_width_p-13){br_instr_i[31]}}, br_instr_i[31], br_instr_i[7],
                    br_instr_i[30:25], br_instr_i[11:8], 1'b0};
    assign w_target       = (br_pc_i + w_imm) & ~vaddr_width_p'(1);
    assign w_backward     = br_v_i && (br_instr_i[6:0] == rv64_branch_opcode_gp) && br_instr_i[31];
    assign w_br_op        = decode_op(br_instr_i[14:12]);
    assign w_unused_instr = ^br_instr_i[24:15];

    genvar gi;
    generate
        for (gi = 0; gi < channels_p; gi++) begin : g_ch
            assign w_start_hit[gi] = start_v_i && (start_id_i == id_width_lp'(gi)) && !r_conf[gi];
            assign w_conf_hit[gi]  = confirm_v_i && (confirm_id_i == id_width_lp'(gi)) && (r_state[gi] != e_idle);
            assign w_scout_acc[gi] = (r_state[gi] == e_scout) && w_backward && (w_target <= r_spc[gi]);
            assign w_wait2_hit[gi] = (r_state[gi] == e_wait2) && br_v_i && (br_pc_i == r_pc[gi]);
            assign w_timeout[gi]   = (r_state[gi] == e_wait2) && (r_timer[gi] == timer_lp'(timeout_p));
            assign w_div_req[gi]   = (r_state[gi] == e_divq) && !r_triv[gi];
            assign w_div_done[gi]  = w_res_v && (w_res_id == lte_id_width_gp'(gi)) && (r_state[gi] == e_div);
            assign w_done[gi]      = (r_state[gi] == e_done);
            assign w_yumi_hit[gi]  = r_v && res_if.yumi_i && (r_out_id == id_width_lp'(gi));
            assign w_norm[gi]      = normalise(r_op[gi], r_rs1[gi], r_rs2[gi], br_rs1_i, br_rs2_i);
        end
    endgenerate

    // round-robin grant among channels waiting for the divider, starting at r_rr
    always_comb begin
        w_grant_v  = 1'b0;
        w_grant_id = '0;
        for (int i = 0; i < channels_p; i++) begin
            if (!w_grant_v && w_div_req[(int'(r_rr) + i) % channels_p]) begin
                w_grant_v  = 1'b1;
                w_grant_id = id_width_lp'((int'(r_rr) + i) % channels_p);
            end
        end
    end
    assign w_div_go = w_grant_v && w_div_ready;

    always_comb begin
        w_div_req_s    = '0;
        w_div_req_s.id = lte_id_width_gp'(w_grant_id);
        w_div_req_s.d  = r_num[w_grant_id];
        w_div_req_s.s  = r_den[w_grant_id];
    end

    bp_be_loop_trip_div u_div (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .req_v_i     (w_grant_v),
        .req_ready_o (w_div_ready),
        .req_i       (w_div_req_s),
        .res_v_o     (w_res_v),
        .res_id_o    (w_res_id),
        .res_quo_o   (w_res_quo)
    );

    assign w_sat = |w_res_quo[W-1:count_width_p];

    always_comb begin
        for (int c = 0; c < channels_p; c++) begin
            w_state_next[c] = r_state[c];
            w_conf_next[c]  = r_conf[c] | w_conf_hit[c];
            if (w_start_hit[c]) begin
                w_state_next[c] = e_scout;
                w_conf_next[c]  = 1'b0;
            end else begin
                case (r_state[c])
                    e_scout: if (w_scout_acc[c]) w_state_next[c] = e_wait2;
                    e_wait2: begin
                        if (w_wait2_hit[c])    w_state_next[c] = e_divq;
                        else if (w_timeout[c]) w_state_next[c] = e_scout;
                    end
                    e_divq: begin
                        if (r_triv[c])
                            w_state_next[c] = w_conf_next[c] ? e_done : e_waitconf;
                        else if (w_div_go && (w_grant_id == id_width_lp'(c)))
                            w_state_next[c] = e_div;
                    end
                    e_div: if (w_div_done[c]) w_state_next[c] = w_conf_next[c] ? e_done : e_waitconf;
                    e_waitconf: if (w_conf_next[c]) w_state_next[c] = e_done;
                    e_done: begin
                        if (w_yumi_hit[c]) begin
                            w_state_next[c] = e_idle;
                            w_conf_next[c]  = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_rr <= '0;
            for (int c = 0; c < channels_p; c++) begin
                r_state[c]    <= e_idle;
                r_conf[c]     <= 1'b0;
                r_triv[c]     <= 1'b0;
                r_exact_ch[c] <= 1'b0;
                r_op[c]       <= e_op_none;
                r_spc[c]      <= '0;
                r_pc[c]       <= '0;
                r_rs1[c]      <= '0;
                r_rs2[c]      <= '0;
                r_num[c]      <= '0;
                r_den[c]      <= '0;
                r_cnt_ch[c]   <= '0;
                r_timer[c]    <= '0;
            end
        end else begin
            if (w_div_go)
                r_rr <= (int'(w_grant_id) == channels_p - 1) ? '0 : w_grant_id + id_width_lp'(1);
            for (int c = 0; c < channels_p; c++) begin
                r_state[c] <= w_state_next[c];
                r_conf[c]  <= w_conf_next[c];
                r_timer[c] <= (r_state[c] == e_wait2 && w_state_next[c] == e_wait2)
                              ? r_timer[c] + timer_lp'(1) : '0;
                if (w_start_hit[c]) begin
                    r_spc[c] <= striding_pc_i;
                    r_pc[c]  <= '0;
                    r_op[c]  <= e_op_none;
                    r_rs1[c] <= '0;
                    r_rs2[c] <= '0;
                end else if (w_scout_acc[c]) begin
                    r_pc[c]  <= br_pc_i;
                    r_op[c]  <= w_br_op;
                    r_rs1[c] <= br_rs1_i;
                    r_rs2[c] <= br_rs2_i;
                end else if (w_wait2_hit[c]) begin
                    r_num[c] <= w_norm[c].d + w_norm[c].s - W'(1);
                    r_den[c] <= w_norm[c].s;
                    if (r_op[c] == e_op_none) begin
                        r_triv[c] <= 1'b1; r_cnt_ch[c] <= count_width_p'(default_count_p); r_exact_ch[c] <= 1'b0;
                    end else if (w_norm[c].d[W-1] || w_norm[c].d == '0) begin
                        r_triv[c] <= 1'b1; r_cnt_ch[c] <= '0; r_exact_ch[c] <= 1'b1;
                    end else if (w_norm[c].s[W-1] || w_norm[c].s == '0) begin
                        r_triv[c] <= 1'b1; r_cnt_ch[c] <= count_width_p'(default_count_p); r_exact_ch[c] <= 1'b0;
                    end else begin
                        r_triv[c] <= 1'b0;
                    end
                end else if (w_div_done[c]) begin
                    r_cnt_ch[c]   <= w_sat ? '1 : w_res_quo[count_width_p-1:0];
                    r_exact_ch[c] <= !w_sat;
                end
            end
        end
    end

    // the channel being retired this cycle must not be re-presented
    assign w_out_mask = w_done & ~w_yumi_hit;

    always_comb begin
        w_sel_v  = 1'b0;
        w_sel_id = '0;
        for (int c = channels_p - 1; c >= 0; c--) begin
            if (w_out_mask[c]) begin
                w_sel_v  = 1'b1;
                w_sel_id = id_width_lp'(c);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_v         <= 1'b0;
            r_out_id    <= '0;
            r_out_cnt   <= '0;
            r_out_exact <= 1'b0;
        end else if (!r_v || res_if.yumi_i) begin
            r_v         <= w_sel_v;
            r_out_id    <= w_sel_v ? w_sel_id : '0;
            r_out_cnt   <= w_sel_v ? r_cnt_ch[w_sel_id] : '0;
            r_out_exact <= w_sel_v && r_exact_ch[w_sel_id];
        end
    end

    assign res_if.v_o          = r_v;
    assign res_if.id_o         = r_out_id;
    assign res_if.trip_count_o = r_out_cnt;
    assign res_if.exact_o      = r_out_exact;
endmodule

// File: tb/tb_bp_be_loop_trip_estimator.sv
// Directed bench for the loop trip estimator: hand-computed trip counts, output hold,
// WAIT2 timeout, restart and reset during division.
module tb_bp_be_loop_trip_estimator;
    logic        clk = 1'b0;
    logic        reset_i;
    logic        br_v_i;
    logic [31:0] br_instr_i;
    logic [38:0] br_pc_i;
    logic [63:0] br_rs1_i, br_rs2_i;
    logic        start_v_i;
    logic [1:0]  start_id_i;
    logic [38:0] striding_pc_i;
    logic        confirm_v_i;
    logic [1:0]  confirm_id_i;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    bp_be_loop_trip_estimator_if #(.id_width_p(2), .count_width_p(8)) res_if ();

    bp_be_loop_trip_estimator dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .br_v_i        (br_v_i),
        .br_instr_i    (br_instr_i),
        .br_pc_i       (br_pc_i),
        .br_rs1_i      (br_rs1_i),
        .br_rs2_i      (br_rs2_i),
        .start_v_i     (start_v_i),
        .start_id_i    (start_id_i),
        .striding_pc_i (striding_pc_i),
        .confirm_v_i   (confirm_v_i),
        .confirm_id_i  (confirm_id_i),
        .res_if        (res_if)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mk_br(input logic [2:0] f3, input int imm);
        logic [12:0] im;
        im = 13'(imm);
        mk_br = {im[12], im[10:5], 5'd2, 5'd1, f3, im[4:1], im[11], 7'b1100011};
    endfunction

    // all drive tasks are entered on a negedge and return on the next negedge
    task automatic br(input logic [38:0] pc, input logic [31:0] ins, input logic [63:0] a, input logic [63:0] b);
        br_v_i = 1'b1; br_pc_i = pc; br_instr_i = ins; br_rs1_i = a; br_rs2_i = b;
        @(negedge clk);
        br_v_i = 1'b0;
    endtask

    task automatic start(input logic [1:0] id, input logic [38:0] pc);
        start_v_i = 1'b1; start_id_i = id; striding_pc_i = pc;
        @(negedge clk);
        start_v_i = 1'b0;
    endtask

    task automatic confirm(input logic [1:0] id);
        confirm_v_i = 1'b1; confirm_id_i = id;
        @(negedge clk);
        confirm_v_i = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic yumi();
        res_if.yumi_i = 1'b1;
        @(negedge clk);
        res_if.yumi_i = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_v"},     64'(res_if.v_o), 0);
        check({tag, "_id"},    64'(res_if.id_o), 0);
        check({tag, "_count"}, 64'(res_if.trip_count_o), 0);
        check({tag, "_exact"}, 64'(res_if.exact_o), 0);
    endtask

    task automatic expect_result(input string tag, input int id, input int cnt, input int ex);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            ok = res_if.v_o;
        end
        check({tag, "_v"},     64'(ok), 1);
        check({tag, "_id"},    64'(res_if.id_o), 64'(id));
        check({tag, "_count"}, 64'(res_if.trip_count_o), 64'(cnt));
        check({tag, "_exact"}, 64'(res_if.exact_o), 64'(ex));
        $display("%s: id=%0d count=%0d exact=%0d", tag, res_if.id_o, res_if.trip_count_o, res_if.exact_o);
        yumi();
    endtask

    localparam logic [2:0] F_BEQ = 3'b000, F_BLT = 3'b100, F_BGE = 3'b101, F_BLTU = 3'b110;

    initial begin
        int vcount;
        reset_i = 1'b1; br_v_i = 1'b0; br_instr_i = '0; br_pc_i = '0; br_rs1_i = '0; br_rs2_i = '0;
        start_v_i = 1'b0; start_id_i = '0; striding_pc_i = '0; confirm_v_i = 1'b0; confirm_id_i = '0;
        res_if.yumi_i = 1'b0;
        idle(3);
        check_outputs_zero("reset");
        reset_i = 1'b0;
        @(negedge clk);

        // BLT rs1 0 -> 1, rs2 100: d = 99, s = 1
        start(0, 39'h1000);
        br(39'h1040, mk_br(F_BLT, -64), 0, 100);
        br(39'h1040, mk_br(F_BLT, -64), 1, 100);
        confirm(0);
        expect_result("blt", 0, 99, 1);
        check("blt_after_yumi_v", 64'(res_if.v_o), 0);

        // BGE rs1 64 -> 60, rs2 0: d = 61, s = 4 -> ceil = 16
        start(0, 39'h1000);
        br(39'h1040, mk_br(F_BGE, -64), 64, 0);
        br(39'h1040, mk_br(F_BGE, -64), 60, 0);
        confirm(0);
        expect_result("bge", 0, 16, 1);

        // BEQ backward branch: no estimate
        start(0, 39'h1000);
        br(39'h1040, mk_br(F_BEQ, -64), 5, 5);
        br(39'h1040, mk_br(F_BEQ, -64), 6, 6);
        confirm(0);
        expect_result("beq", 0, 128, 0);

        // static operands: s = 0
        start(0, 39'h1000);
        br(39'h1040, mk_br(F_BLT, -64), 5, 10);
        br(39'h1040, mk_br(F_BLT, -64), 5, 10);
        confirm(0);
        expect_result("static", 0, 128, 0);

        // BLTU d = 1000, s = 1 saturates; a branch whose target lies above the load is skipped first
        start(0, 39'h1000);
        br(39'h2000, mk_br(F_BLTU, -64), 0, 1001);
        br(39'h1040, mk_br(F_BLTU, -64), 0, 1001);
        br(39'h1040, mk_br(F_BLTU, -64), 1, 1001);
        confirm(0);
        expect_result("bltu_sat", 0, 255, 0);

        // ch1 and ch2 see the same branch and finish together; ch1 held, then ch2
        start(1, 39'h1000);
        start(2, 39'h1000);
        confirm(1);
        confirm(2);
        br(39'h1040, mk_br(F_BEQ, -64), 3, 3);
        br(39'h1040, mk_br(F_BEQ, -64), 4, 4);
        vcount = 0;
        for (int i = 0; i < 20 && !res_if.v_o; i++) @(negedge clk);
        check("pair_first_id", 64'(res_if.id_o), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("pair_hold_v",     64'(res_if.v_o), 1);
            check("pair_hold_id",    64'(res_if.id_o), 1);
            check("pair_hold_count", 64'(res_if.trip_count_o), 128);
        end
        $display("pair: id=%0d count=%0d held", res_if.id_o, res_if.trip_count_o);
        yumi();
        check("pair_second_v",  64'(res_if.v_o), 1);
        check("pair_second_id", 64'(res_if.id_o), 2);
        $display("pair: id=%0d count=%0d", res_if.id_o, res_if.trip_count_o);
        yumi();
        check("pair_drained_v", 64'(res_if.v_o), 0);

        // confirm to an idle channel is ignored, so the start below must still take
        confirm(3);
        start(3, 39'h1000);
        br(39'h1040, mk_br(F_BLT, -64), 0, 10);
        idle(1100);
        br(39'h1080, mk_br(F_BLT, -128), 0, 10);
        br(39'h1080, mk_br(F_BLT, -128), 2, 10);
        confirm(3);
        expect_result("timeout_rescout", 3, 4, 1);

        // restart while dividing: stale quotient must never appear
        start(0, 39'h1000);
        br(39'h1040, mk_br(F_BLT, -64), 0, 100);
        br(39'h1040, mk_br(F_BLT, -64), 1, 100);
        idle(10);
        start(0, 39'h1000);
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (res_if.v_o) vcount++;
        end
        check("restart_no_result", 64'(vcount), 0);
        br(39'h1040, mk_br(F_BLT, -64), 0, 10);
        br(39'h1040, mk_br(F_BLT, -64), 1, 10);
        confirm(0);
        expect_result("restart_fresh", 0, 9, 1);

        // reset during division
        start(0, 39'h1000);
        br(39'h1040, mk_br(F_BLT, -64), 0, 100);
        br(39'h1040, mk_br(F_BLT, -64), 1, 100);
        confirm(0);
        idle(10);
        reset_i = 1'b1;
        idle(2);
        reset_i = 1'b0;
        @(negedge clk);
        check_outputs_zero("div_reset");
        vcount = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (res_if.v_o) vcount++;
        end
        check("div_reset_no_result", 64'(vcount), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
